dmem_responder: RTL

Data-memory responder for the RV64 core: the target end of the core's load/store port. It accepts one request at a time over a valid/ready handshake and services it after a fixed, parameterised latency. Stores are merged into 64-bit words by byte lane. Loads are returned extracted and sign- or zero-extended per RV64 funct3. It replaces the core's combinational data memory once the datapath moves to a stalling, multi-cycle memory interface.

---
 rtl/dmem_pkg.sv | 40 ++++
 rtl/dmem_lane_align.sv | 69 ++++++
 rtl/dmem_responder.sv | 132 +++++++++++++
 3 files changed

// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types and helpers for the data-memory responder.
//   size_e     - RV64 load/store funct3 encodings (111 is reserved/illegal).
//   state_e    - responder FSM states.
//   size_bytes - number of bytes touched by an access of a given funct3.
//   size_signed- 1 when a load of that funct3 is sign-extended.
package dmem_pkg;

    typedef enum logic [2:0] {
        SZ_B   = 3'b000,
        SZ_H   = 3'b001,
        SZ_W   = 3'b010,
        SZ_D   = 3'b011,
        SZ_BU  = 3'b100,
        SZ_HU  = 3'b101,
        SZ_WU  = 3'b110,
        SZ_BAD = 3'b111
    } size_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    // Unsigned variants share the width of their signed counterparts, so a
    // store with size 1xx behaves exactly like 0xx.
    function automatic logic [3:0] size_bytes(input logic [2:0] size);
        case (size)
            SZ_B, SZ_BU: return 4'd1;
            SZ_H, SZ_HU: return 4'd2;
            SZ_W, SZ_WU: return 4'd4;
            default:     return 4'd8;
        endcase
    endfunction

    function automatic logic size_signed(input logic [2:0] size);
        return (size == SZ_B) || (size == SZ_H) || (size == SZ_W);
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// dmem_lane_align: combinational byte-lane steering for one 64-bit word.
//   word       in  - current memory word (little-endian lanes).
//   offset     in  - byte offset within the word (addr[2:0]).
//   size       in  - funct3 access size.
//   wdata      in  - store data, low bytes significant.
//   load_data  out - extracted and sign/zero-extended load result.
//   store_word out - word with the access's byte lanes replaced by wdata.
//   misaligned out - offset not a multiple of the access size.
// Build option DMEM_RESP_MISALIGN_CHK_EN: when defined, misaligned offsets are
// flagged; when undefined, the offset is silently rounded down to the size.
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [63:0] word,
    input  logic [2:0]  offset,
    input  logic [2:0]  size,
    input  logic [63:0] wdata,
    output logic [63:0] load_data,
    output logic [63:0] store_word,
    output logic        misaligned
);

    logic [3:0]  nbytes;
    logic [3:0]  nbytes_m1;
    logic [2:0]  low_mask;
    logic [2:0]  eff_off;
    logic [63:0] lane_word;
    logic [63:0] lane_wdata;
    logic [7:0]  lane_en;
    logic        sext;

    assign nbytes    = size_bytes(size);
    assign nbytes_m1 = nbytes - 4'd1;
    // Offset bits that must be zero for a naturally aligned access.
    assign low_mask  = nbytes_m1[2:0];
    assign sext      = size_signed(size);

`ifdef DMEM_RESP_MISALIGN_CHK_EN
    assign misaligned = |(offset & low_mask);
    assign eff_off    = offset;
`else
    assign misaligned = 1'b0;
    assign eff_off    = offset & ~low_mask;
`endif

    assign lane_word  = word >> {eff_off, 3'b000};
    assign lane_wdata = wdata << {eff_off, 3'b000};

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_lane
            localparam logic [3:0] LANE = 4'(gi);
            assign lane_en[gi] = (LANE >= {1'b0, eff_off}) &&
                                 (LANE <  ({1'b0, eff_off} + nbytes));
            assign store_word[8*gi +: 8] = lane_en[gi] ? lane_wdata[8*gi +: 8]
                                                       : word[8*gi +: 8];
        end
    endgenerate

    always_comb begin
        case (size[1:0])
            2'b00:   load_data = {{56{sext & lane_word[7]}},  lane_word[7:0]};
            2'b01:   load_data = {{48{sext & lane_word[15]}}, lane_word[15:0]};
            2'b10:   load_data = {{32{sext & lane_word[31]}}, lane_word[31:0]};
            default: load_data = lane_word;
        endcase
    end

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: fixed-latency data-memory target for the RV64 load/store port.
//   clk, reset (async, active-high)
//   req_valid/req_ready/req_write/req_addr/req_size/req_wdata - request channel
//   rsp_valid/rsp_ready/rsp_rdata/rsp_err                      - response channel
// Parameters: DEPTH (64-bit words, power of two), LATENCY (accept->rsp_valid).
// Build option DMEM_RESP_MISALIGN_CHK_EN enables misalignment faults (see
// dmem_lane_align); without it misaligned offsets are rounded down.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH   = 512,
    parameter int LATENCY = 2
)
(
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [63:0] req_addr,
    input  logic [2:0]  req_size,
    input  logic [63:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [63:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CW-1:0] CNT_INIT = CW'(LATENCY - 1);

    localparam logic [1:0] IDLE = 2'(ST_IDLE);
    localparam logic [1:0] WAIT = 2'(ST_WAIT);
    localparam logic [1:0] RESP = 2'(ST_RESP);

    logic [1:0]    state_reg;
    logic [CW-1:0] cnt_reg;
    logic          write_reg;
    logic [63:0]   addr_reg;
    logic [2:0]    size_reg;
    logic [63:0]   wdata_reg;
    logic [63:0]   rd_word_reg;
    logic [63:0]   rdata_reg;
    logic          err_reg;

    logic [63:0]   mem [DEPTH];

    logic          accept;
    logic          access;
    logic          out_of_range;
    logic          acc_err;
    logic          do_write;
    logic [63:0]   load_data;
    logic [63:0]   store_word;
    logic          misaligned;

    assign req_ready = (state_reg == IDLE);
    assign rsp_valid = (state_reg == RESP);
    assign rsp_rdata = rdata_reg;
    assign rsp_err   = err_reg;

    assign accept       = req_valid && (state_reg == IDLE);
    assign access       = (state_reg == WAIT) && (cnt_reg == '0);
    assign out_of_range = |addr_reg[63:3+AW];
    assign acc_err      = out_of_range || (size_reg == SZ_BAD) || misaligned;
    assign do_write     = access && write_reg && !acc_err;

    dmem_lane_align u_align (
        .word       (rd_word_reg),
        .offset     (addr_reg[2:0]),
        .size       (size_reg),
        .wdata      (wdata_reg),
        .load_data  (load_data),
        .store_word (store_word),
        .misaligned (misaligned)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            write_reg <= 1'b0;
            addr_reg  <= '0;
            size_reg  <= '0;
            wdata_reg <= '0;
            rdata_reg <= '0;
            err_reg   <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (req_valid) begin
                        write_reg <= req_write;
                        addr_reg  <= req_addr;
                        size_reg  <= req_size;
                        wdata_reg <= req_wdata;
                        cnt_reg   <= CNT_INIT;
                        state_reg <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt_reg == '0) begin
                        rdata_reg <= (write_reg || acc_err) ? 64'd0 : load_data;
                        err_reg   <= acc_err;
                        state_reg <= RESP;
                    end else begin
                        cnt_reg <= cnt_reg - 1'b1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    // Storage is deliberately unreset. The word is fetched on the accept edge
    // straight from req_addr so it is already registered by the access edge,
    // even for LATENCY=1; stores are a read-modify-write of that word.
    always_ff @(posedge clk) begin
        if (accept) begin
            rd_word_reg <= mem[req_addr[3 +: AW]];
        end
        if (do_write) begin
            mem[addr_reg[3 +: AW]] <= store_word;
        end
    end

endmodule
